// File: rtl/corr_acc_nc_if.sv
// Sample-in / result-out bundle of the correlator accumulator.
// The master side drives the rx_* samples and control; the slave side returns the tx_* results.
interface corr_acc_nc_if #(
  parameter int DAT_WIDTH  = 16,
  parameter int CORR_WIDTH = 32,
  parameter int NC_WIDTH   = 72,
  parameter int PHS_WIDTH  = 12
);
  logic                         rx_valid;
  logic signed [DAT_WIDTH-1:0]  rx_data_real;
  logic signed [DAT_WIDTH-1:0]  rx_data_imag;
  logic                         rx_loc_boc;
  logic                         rx_prn_sop;
  logic                         rx_prn_eop;
  logic [PHS_WIDTH-1:0]         rx_prn_phs;
  logic                         rx_search_clr;

  logic signed [CORR_WIDTH-1:0] tx_corr_real;
  logic signed [CORR_WIDTH-1:0] tx_corr_imag;
  logic                         tx_corr_vld;
  logic [NC_WIDTH-1:0]          tx_nc_pow;
  logic [PHS_WIDTH-1:0]         tx_nc_phs;
  logic                         tx_nc_vld;
  logic [NC_WIDTH-1:0]          tx_peak_pow;
  logic [PHS_WIDTH-1:0]         tx_peak_phs;
  logic                         tx_sat;

  modport master (
    output rx_valid, rx_data_real, rx_data_imag, rx_loc_boc,
           rx_prn_sop, rx_prn_eop, rx_prn_phs, rx_search_clr,
    input  tx_corr_real, tx_corr_imag, tx_corr_vld, tx_nc_pow, tx_nc_phs,
           tx_nc_vld, tx_peak_pow, tx_peak_phs, tx_sat
  );

  modport slave (
    input  rx_valid, rx_data_real, rx_data_imag, rx_loc_boc,
           rx_prn_sop, rx_prn_eop, rx_prn_phs, rx_search_clr,
    output tx_corr_real, tx_corr_imag, tx_corr_vld, tx_nc_pow, tx_nc_phs,
           tx_nc_vld, tx_peak_pow, tx_peak_phs, tx_sat
  );
endinterface

// File: rtl/corr_acc_nc.sv
// Coherent I/Q correlator with saturating accumulate, I^2+Q^2 power, non-coherent
// summation over NC_NUM periods and a running peak search. Fully pipelined, no stall.
module corr_acc_nc #(
  parameter int DAT_WIDTH  = 16,
  parameter int CORR_WIDTH = 32,
  parameter int NC_WIDTH   = 72,
  parameter int NC_NUM     = 4,
  parameter int PHS_WIDTH  = 12
) (
  input  logic          rx_clk,
  input  logic          rx_rst,
  corr_acc_nc_if.slave  bus
);
  localparam int POW_WIDTH = 2 * CORR_WIDTH;
  // Two guard bits: one for the negated most-negative sample, one for the add.
  localparam int EXT_WIDTH = CORR_WIDTH + 2;
  localparam logic signed [EXT_WIDTH-1:0] CORR_MAX = {3'b000, {(CORR_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_WIDTH-1:0] CORR_MIN = {3'b111, {(CORR_WIDTH-1){1'b0}}};
  localparam logic [7:0] NC_LAST = 8'(NC_NUM - 1);

  function automatic logic signed [EXT_WIDTH-1:0] corr_prod(
    input logic signed [DAT_WIDTH-1:0] s,
    input logic                        boc
  );
    logic signed [EXT_WIDTH-1:0] ext;
    ext = EXT_WIDTH'(s);
    return boc ? ext : -ext;
  endfunction

  // Returns {overflow, clamped value}.
  function automatic logic [CORR_WIDTH:0] clamp(input logic signed [EXT_WIDTH-1:0] raw);
    if (raw > CORR_MAX) return {1'b1, CORR_MAX[CORR_WIDTH-1:0]};
    if (raw < CORR_MIN) return {1'b1, CORR_MIN[CORR_WIDTH-1:0]};
    return {1'b0, raw[CORR_WIDTH-1:0]};
  endfunction

  logic                         eop_ok;
  logic signed [EXT_WIDTH-1:0]  sum_i, sum_q;
  logic signed [CORR_WIDTH-1:0] clamp_i, clamp_q;
  logic                         ovf_i, ovf_q;

  logic signed [CORR_WIDTH-1:0] acc_i_q, acc_q_q, acc_i_d, acc_q_d;
  logic signed [CORR_WIDTH-1:0] corr_i_q, corr_q_q;
  logic                         corr_vld_q;
  logic [PHS_WIDTH-1:0]         corr_phs_q;
  logic [POW_WIDTH-1:0]         sq_i_q, sq_q_q;
  logic                         sq_vld_q;
  logic [PHS_WIDTH-1:0]         sq_phs_q;
  logic [POW_WIDTH-1:0]         pow_q;
  logic                         pow_vld_q;
  logic [PHS_WIDTH-1:0]         pow_phs_q;

  logic [NC_WIDTH:0]            nc_raw;
  logic [NC_WIDTH-1:0]          nc_total;
  logic [NC_WIDTH-1:0]          nc_sum_q, nc_sum_d, nc_pow_q, nc_pow_d;
  logic [7:0]                   nc_cnt_q, nc_cnt_d;
  logic [PHS_WIDTH-1:0]         nc_phs_q, nc_phs_d;
  logic                         nc_vld_q, nc_vld_d;
  logic [NC_WIDTH-1:0]          peak_pow_q, peak_pow_d;
  logic [PHS_WIDTH-1:0]         peak_phs_q, peak_phs_d;
  logic                         sat_q, sat_d;

  assign eop_ok = bus.rx_valid & bus.rx_prn_eop;

  assign sum_i = (bus.rx_prn_sop ? '0 : EXT_WIDTH'(acc_i_q))
               + corr_prod(bus.rx_data_real, bus.rx_loc_boc);
  assign sum_q = (bus.rx_prn_sop ? '0 : EXT_WIDTH'(acc_q_q))
               + corr_prod(bus.rx_data_imag, bus.rx_loc_boc);
  assign {ovf_i, clamp_i} = clamp(sum_i);
  assign {ovf_q, clamp_q} = clamp(sum_q);

  assign nc_raw   = {1'b0, nc_sum_q} + (NC_WIDTH + 1)'(pow_q);
  assign nc_total = nc_raw[NC_WIDTH] ? '1 : nc_raw[NC_WIDTH-1:0];

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    acc_i_d    = acc_i_q;
    acc_q_d    = acc_q_q;
    nc_sum_d   = nc_sum_q;
    nc_cnt_d   = nc_cnt_q;
    nc_pow_d   = nc_pow_q;
    nc_phs_d   = nc_phs_q;
    nc_vld_d   = 1'b0;
    peak_pow_d = peak_pow_q;
    peak_phs_d = peak_phs_q;
    sat_d      = sat_q & ~bus.rx_search_clr;

    if (bus.rx_valid) begin
      acc_i_d = clamp_i;
      acc_q_d = clamp_q;
      if (ovf_i | ovf_q) sat_d = 1'b1;
    end

    if (pow_vld_q) begin
      if (nc_cnt_q == NC_LAST) begin
        nc_pow_d = nc_total;
        nc_phs_d = pow_phs_q;
        nc_vld_d = 1'b1;
        nc_sum_d = '0;
        nc_cnt_d = '0;
      end else begin
        nc_sum_d = nc_total;
        nc_cnt_d = nc_cnt_q + 8'd1;
      end
    end

    // A clear coinciding with a fresh result reloads from that result.
    if (nc_vld_q && (bus.rx_search_clr || nc_pow_q > peak_pow_q)) begin
      peak_pow_d = nc_pow_q;
      peak_phs_d = nc_phs_q;
    end else if (bus.rx_search_clr) begin
      peak_pow_d = '0;
      peak_phs_d = '0;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      acc_i_q    <= '0;
      acc_q_q    <= '0;
      corr_i_q   <= '0;
      corr_q_q   <= '0;
      corr_vld_q <= 1'b0;
      corr_phs_q <= '0;
      sq_i_q     <= '0;
      sq_q_q     <= '0;
      sq_vld_q   <= 1'b0;
      sq_phs_q   <= '0;
      pow_q      <= '0;
      pow_vld_q  <= 1'b0;
      pow_phs_q  <= '0;
      nc_sum_q   <= '0;
      nc_cnt_q   <= '0;
      nc_pow_q   <= '0;
      nc_phs_q   <= '0;
      nc_vld_q   <= 1'b0;
      peak_pow_q <= '0;
      peak_phs_q <= '0;
      sat_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every stage samples the previous stage's pre-edge value.
      acc_i_q    <= acc_i_d;
      acc_q_q    <= acc_q_d;
      corr_vld_q <= eop_ok;
      if (eop_ok) begin
        corr_i_q   <= clamp_i;
        corr_q_q   <= clamp_q;
        corr_phs_q <= bus.rx_prn_phs;
      end
      sq_vld_q <= corr_vld_q;
      if (corr_vld_q) begin
        sq_i_q   <= POW_WIDTH'(corr_i_q) * POW_WIDTH'(corr_i_q);
        sq_q_q   <= POW_WIDTH'(corr_q_q) * POW_WIDTH'(corr_q_q);
        sq_phs_q <= corr_phs_q;
      end
      // Each square is at most 2^(2*CORR_WIDTH-2), so the sum cannot wrap.
      pow_vld_q <= sq_vld_q;
      if (sq_vld_q) begin
        pow_q     <= sq_i_q + sq_q_q;
        pow_phs_q <= sq_phs_q;
      end
      nc_sum_q   <= nc_sum_d;
      nc_cnt_q   <= nc_cnt_d;
      nc_pow_q   <= nc_pow_d;
      nc_phs_q   <= nc_phs_d;
      nc_vld_q   <= nc_vld_d;
      peak_pow_q <= peak_pow_d;
      peak_phs_q <= peak_phs_d;
      sat_q      <= sat_d;
    end
  end

  assign bus.tx_corr_real = corr_i_q;
  assign bus.tx_corr_imag = corr_q_q;
  assign bus.tx_corr_vld  = corr_vld_q;
  assign bus.tx_nc_pow    = nc_pow_q;
  assign bus.tx_nc_phs    = nc_phs_q;
  assign bus.tx_nc_vld    = nc_vld_q;
  assign bus.tx_peak_pow  = peak_pow_q;
  assign bus.tx_peak_phs  = peak_phs_q;
  assign bus.tx_sat       = sat_q;
endmodule

// File: tb/tb_corr_acc_nc.sv
// Bench for corr_acc_nc: DUT A uses default widths with NC_NUM=4, DUT B uses
// CORR_WIDTH=16 with NC_NUM=1; expected results flow through per-DUT scoreboards.
module tb_corr_acc_nc;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  corr_acc_nc_if ifa ();
  corr_acc_nc_if #(.CORR_WIDTH(16), .NC_WIDTH(40)) ifb ();

  corr_acc_nc #(.NC_NUM(4)) u_dut_a (
    .rx_clk (clk),
    .rx_rst (rst),
    .bus    (ifa)
  );

  corr_acc_nc #(.CORR_WIDTH(16), .NC_WIDTH(40), .NC_NUM(1)) u_dut_b (
    .rx_clk (clk),
    .rx_rst (rst),
    .bus    (ifb)
  );

  typedef struct { longint re; longint im; } corr_t;
  typedef struct { longint pow; int phs; } nc_t;

  corr_t qa_corr[$], qb_corr[$];
  nc_t   qa_nc[$], qb_nc[$];
  int    n_pass = 0;
  int    n_fail = 0;
  int    n_total = 0;

  task automatic check(input string tag, input logic signed [127:0] obs, input logic signed [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input bit v, input int re, input int im, input bit boc,
                       input bit sop, input bit eop, input int phs);
    ifa.rx_valid = v; ifa.rx_data_real = 16'(re); ifa.rx_data_imag = 16'(im);
    ifa.rx_loc_boc = boc; ifa.rx_prn_sop = sop; ifa.rx_prn_eop = eop; ifa.rx_prn_phs = 12'(phs);
    tick();
    ifa.rx_valid = 1'b0; ifa.rx_prn_sop = 1'b0; ifa.rx_prn_eop = 1'b0;
  endtask

  task automatic drv_b(input bit v, input int re, input int im, input bit boc,
                       input bit sop, input bit eop, input int phs);
    ifb.rx_valid = v; ifb.rx_data_real = 16'(re); ifb.rx_data_imag = 16'(im);
    ifb.rx_loc_boc = boc; ifb.rx_prn_sop = sop; ifb.rx_prn_eop = eop; ifb.rx_prn_phs = 12'(phs);
    tick();
    ifb.rx_valid = 1'b0; ifb.rx_prn_sop = 1'b0; ifb.rx_prn_eop = 1'b0;
  endtask

  task automatic clr_b();
    ifb.rx_search_clr = 1'b1;
    tick();
    ifb.rx_search_clr = 1'b0;
  endtask

  task automatic exp_a(input longint re, input longint im);
    qa_corr.push_back('{re, im});
  endtask
  task automatic exp_b(input longint re, input longint im);
    qb_corr.push_back('{re, im});
  endtask
  task automatic exp_b_nc(input longint pow, input int phs);
    qb_nc.push_back('{pow, phs});
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while ((qa_corr.size() + qb_corr.size() + qa_nc.size() + qb_nc.size()) != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    check("drain_pending", qa_corr.size() + qb_corr.size() + qa_nc.size() + qb_nc.size(), 0);
  endtask

  // Scoreboard side: every strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    corr_t ce;
    nc_t   ne;
    if (ifa.tx_corr_vld) begin
      if (qa_corr.size() == 0) check("a_corr_unexpected", 1, 0);
      else begin
        ce = qa_corr.pop_front();
        check("a_corr_real", $signed(ifa.tx_corr_real), ce.re);
        check("a_corr_imag", $signed(ifa.tx_corr_imag), ce.im);
      end
    end
    if (ifa.tx_nc_vld) begin
      if (qa_nc.size() == 0) check("a_nc_unexpected", 1, 0);
      else begin
        ne = qa_nc.pop_front();
        check("a_nc_pow", ifa.tx_nc_pow, ne.pow);
        check("a_nc_phs", ifa.tx_nc_phs, ne.phs);
      end
    end
    if (ifb.tx_corr_vld) begin
      if (qb_corr.size() == 0) check("b_corr_unexpected", 1, 0);
      else begin
        ce = qb_corr.pop_front();
        check("b_corr_real", $signed(ifb.tx_corr_real), ce.re);
        check("b_corr_imag", $signed(ifb.tx_corr_imag), ce.im);
      end
    end
    if (ifb.tx_nc_vld) begin
      if (qb_nc.size() == 0) check("b_nc_unexpected", 1, 0);
      else begin
        ne = qb_nc.pop_front();
        check("b_nc_pow", ifb.tx_nc_pow, ne.pow);
        check("b_nc_phs", ifb.tx_nc_phs, ne.phs);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time %0t exceeded, required finish before 300000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ifa.rx_valid = 1'b0; ifa.rx_data_real = '0; ifa.rx_data_imag = '0; ifa.rx_loc_boc = 1'b0;
    ifa.rx_prn_sop = 1'b0; ifa.rx_prn_eop = 1'b0; ifa.rx_prn_phs = '0; ifa.rx_search_clr = 1'b0;
    ifb.rx_valid = 1'b0; ifb.rx_data_real = '0; ifb.rx_data_imag = '0; ifb.rx_loc_boc = 1'b0;
    ifb.rx_prn_sop = 1'b0; ifb.rx_prn_eop = 1'b0; ifb.rx_prn_phs = '0; ifb.rx_search_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("a_rst_corr_vld", ifa.tx_corr_vld, 0);
    check("a_rst_nc_pow", ifa.tx_nc_pow, 0);
    check("a_rst_peak_pow", ifa.tx_peak_pow, 0);
    check("b_rst_corr_real", ifb.tx_corr_real, 0);
    check("b_rst_sat", ifb.tx_sat, 0);

    // 4-sample period, boc=1, with strobe latency checks
    exp_b(400, -200); exp_b_nc(200000, 'h11);
    drv_b(1, 100, -50, 1, 1, 0, 0);
    drv_b(1, 100, -50, 1, 0, 0, 0);
    drv_b(1, 100, -50, 1, 0, 0, 0);
    drv_b(1, 100, -50, 1, 0, 1, 'h11);
    check("b_corr_vld_t1", ifb.tx_corr_vld, 1);
    tick(); tick();
    check("b_nc_vld_t3", ifb.tx_nc_vld, 0);
    tick();
    check("b_nc_vld_t4", ifb.tx_nc_vld, 1);
    tick();
    check("b_corr_hold", $signed(ifb.tx_corr_real), 400);
    check("b_nc_pow_hold", ifb.tx_nc_pow, 200000);

    // Same samples with boc=0
    exp_b(-400, 200); exp_b_nc(200000, 'h12);
    drv_b(1, 100, -50, 0, 1, 0, 0);
    drv_b(1, 100, -50, 0, 0, 0, 0);
    drv_b(1, 100, -50, 0, 0, 0, 0);
    drv_b(1, 100, -50, 0, 0, 1, 'h12);
    wait_drain(20);

    // Unqualified controls are ignored; an eop without sop continues the sum
    drv_b(0, 999, 999, 1, 1, 1, 'h7f);
    drv_b(0, 999, 999, 1, 1, 1, 'h7f);
    exp_b(-390, 200); exp_b_nc(192100, 'h13);
    drv_b(1, 10, 0, 1, 0, 1, 'h13);
    wait_drain(20);

    // Saturation at max, negation of the most negative sample, and at min
    exp_b(32767, 0); exp_b_nc(1073676289, 'h20);
    drv_b(1, 32767, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) drv_b(1, 32767, 0, 1, 0, 0, 0);
    drv_b(1, 32767, 0, 1, 0, 1, 'h20);
    check("b_sat_set", ifb.tx_sat, 1);
    exp_b(32767, 0); exp_b_nc(1073676289, 'h21);
    drv_b(1, -32768, 0, 0, 1, 1, 'h21);
    exp_b(-32768, 0); exp_b_nc(1073741824, 'h22);
    drv_b(1, -32768, 0, 1, 1, 0, 0);
    drv_b(1, -32768, 0, 1, 0, 1, 'h22);
    wait_drain(20);
    tick();
    check("b_peak_pow_max", ifb.tx_peak_pow, 1073741824);
    check("b_peak_phs_max", ifb.tx_peak_phs, 'h22);
    check("b_sat_sticky", ifb.tx_sat, 1);
    clr_b();
    check("b_clr_sat", ifb.tx_sat, 0);
    check("b_clr_peak_pow", ifb.tx_peak_pow, 0);
    check("b_clr_peak_phs", ifb.tx_peak_phs, 0);

    // Peak search: strict greater wins, ties keep the earlier phase
    exp_b(5, 5); exp_b_nc(50, 1);
    exp_b(9, 3); exp_b_nc(90, 2);
    exp_b(9, 3); exp_b_nc(90, 3);
    drv_b(1, 5, 5, 1, 1, 1, 1);
    drv_b(1, 9, 3, 1, 1, 1, 2);
    drv_b(1, 9, 3, 1, 1, 1, 3);
    wait_drain(20);
    tick();
    check("b_peak_pow_tie", ifb.tx_peak_pow, 90);
    check("b_peak_phs_tie", ifb.tx_peak_phs, 2);
    exp_b(1, 3); exp_b_nc(10, 4);
    drv_b(1, 1, 3, 1, 1, 1, 4);
    tick(); tick(); tick();
    check("b_nc_vld_at_clr", ifb.tx_nc_vld, 1);
    clr_b();
    check("b_peak_pow_clr_load", ifb.tx_peak_pow, 10);
    check("b_peak_phs_clr_load", ifb.tx_peak_phs, 4);
    wait_drain(20);

    // NC_NUM=4, back-to-back 1-sample periods
    for (int p = 5; p <= 8; p++) exp_a(3, 4);
    qa_nc.push_back('{100, 8});
    for (int p = 5; p <= 8; p++) drv_a(1, 3, 4, 1, 1, 1, p);
    wait_drain(20);
    tick();
    check("a_peak_pow", ifa.tx_peak_pow, 100);
    check("a_peak_phs", ifa.tx_peak_phs, 8);

    // Reset one cycle after eop discards the in-flight power/nc result
    exp_b(32767, 10);
    drv_b(1, 32767, 5, 1, 1, 0, 0);
    drv_b(1, 32767, 5, 1, 0, 1, 'h40);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("b_rr_corr_vld", ifb.tx_corr_vld, 0);
    check("b_rr_corr_real", ifb.tx_corr_real, 0);
    check("b_rr_corr_imag", ifb.tx_corr_imag, 0);
    check("b_rr_nc_pow", ifb.tx_nc_pow, 0);
    check("b_rr_nc_phs", ifb.tx_nc_phs, 0);
    check("b_rr_peak_pow", ifb.tx_peak_pow, 0);
    check("b_rr_peak_phs", ifb.tx_peak_phs, 0);
    check("b_rr_sat", ifb.tx_sat, 0);
    check("a_rr_peak_pow", ifa.tx_peak_pow, 0);
    check("a_rr_nc_phs", ifa.tx_nc_phs, 0);
    for (int i = 0; i < 8; i++) tick();
    check("b_rr_corr_pending", qb_corr.size(), 0);

    // Samples before the first sop after reset accumulate from zero
    exp_b(8, -2); exp_b_nc(68, 'h30);
    drv_b(1, 7, -2, 1, 0, 0, 0);
    drv_b(1, 1, 0, 1, 0, 1, 'h30);
    wait_drain(20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/corr_acc_nc.md
CORR_ACC_NC -- requirements
Module: corr_acc_nc

Interface
Parameters (name, default, meaning):
REQ-001 SHALL provide DAT_WIDTH, 16: signed I/Q sample width.
REQ-002 SHALL provide CORR_WIDTH, 32: signed coherent accumulator width; POW_WIDTH = 2*CORR_WIDTH is derived.
REQ-003 SHALL provide NC_WIDTH, 72: unsigned non-coherent sum width.
REQ-004 SHALL provide NC_NUM, 4: coherent periods per non-coherent sum; legal range 1..255.
REQ-005 SHALL provide PHS_WIDTH, 12: code phase tag width.
Ports (name, direction, width, meaning):
REQ-006 SHALL provide rx_clk, in, 1: single clock; rx_rst, in, 1: reset, synchronous and active-high.
REQ-007 SHALL provide rx_valid, in, 1: sample strobe; rx_data_real and rx_data_imag, in, DAT_WIDTH: signed samples.
REQ-008 SHALL provide rx_loc_boc, in, 1: local chip, 1 = +1 and 0 = -1.
REQ-009 SHALL provide rx_prn_sop and rx_prn_eop, in, 1 each: first and last sample of a PRN period, qualified by rx_valid.
REQ-010 SHALL provide rx_prn_phs, in, PHS_WIDTH: phase tag, sampled on a qualified eop.
REQ-011 SHALL provide rx_search_clr, in, 1: clears the peak search and the tx_sat flag.
REQ-012 SHALL provide tx_corr_real and tx_corr_imag, out, CORR_WIDTH: coherent result; tx_corr_vld, out, 1: strobe.
REQ-013 SHALL provide tx_nc_pow, out, NC_WIDTH; tx_nc_phs, out, PHS_WIDTH; tx_nc_vld, out, 1: non-coherent result.
REQ-014 SHALL provide tx_peak_pow, out, NC_WIDTH; tx_peak_phs, out, PHS_WIDTH: peak search result. tx_sat, out, 1: sticky saturation flag.

Function
REQ-015 Correlation product p SHALL be the sign-extended sample when rx_loc_boc=1 and its two's-complement negation when rx_loc_boc=0, applied per I and Q.
REQ-016 With rx_valid=1: if sop=1, acc <= p; otherwise acc <= acc+p. With rx_valid=0: acc holds, and sop, eop and phs are ignored.
REQ-017 Accumulation SHALL saturate to the signed CORR_WIDTH max or min; any saturation event SHALL set tx_sat.
REQ-018 On a qualified eop in cycle T, tx_corr_* SHALL equal the accumulation including the eop sample, and tx_corr_vld SHALL pulse for 1 cycle at T+1.
REQ-019 sop and eop in the same cycle SHALL give tx_corr = p.
REQ-020 An eop with no preceding sop SHALL continue the running sum.
REQ-021 Power SHALL be I^2+Q^2, unsigned POW_WIDTH, with no overflow possible. Squares SHALL be registered at T+2 and the sum at T+3.
REQ-022 A non-coherent counter SHALL run 0..NC_NUM-1, incrementing on each power result.
REQ-023 When count = NC_NUM-1: tx_nc_pow <= sum+pow; tx_nc_phs <= the phase tag of that period; tx_nc_vld pulses at T+4; sum and count clear.
REQ-024 The non-coherent sum SHALL saturate to all-ones.
REQ-025 With NC_NUM=1, every period SHALL produce tx_nc_vld.
REQ-026 Back-to-back periods SHALL be supported, including 1-sample periods every cycle: full throughput, no stall.
REQ-027 On tx_nc_vld, if tx_nc_pow > tx_peak_pow (strictly greater), tx_peak_pow and tx_peak_phs SHALL update; ties keep the earlier phase.
REQ-028 rx_search_clr SHALL zero tx_peak_pow, tx_peak_phs and tx_sat next cycle. It SHALL NOT affect the accumulators or the pipeline.
REQ-029 If rx_search_clr and an nc result coincide, the peak SHALL load the new result.
REQ-030 tx_* outputs SHALL hold between strobes.

Reset
REQ-031 rx_rst SHALL take effect at the next rx_clk edge.
REQ-032 On reset: all accumulators, the non-coherent count, pipeline valids and every output SHALL be 0.
REQ-033 Reset mid-period or mid-pipeline SHALL discard in-flight data; no strobe SHALL follow.
REQ-034 After reset deassertion, samples before the first sop SHALL accumulate from 0.

Verification
REQ-035 NC_NUM=1; 4 samples with I=100, Q=-50, boc=1, sop on sample 1, eop on sample 4 -> corr = 400/-200 at T+1; nc_pow = 200000 at T+4.
REQ-036 Same samples with boc=0 -> corr = -400/+200; nc_pow = 200000.
REQ-037 NC_NUM=4; periods with I=3, Q=4 (1 sample each, sop=eop=1) and phs 5..8 -> a single tx_nc_vld; nc_pow = 100; nc_phs = 8.
REQ-038 Drive I=32767 each cycle with CORR_WIDTH=16 -> accumulator pins at 32767; tx_sat=1 until rx_search_clr.
REQ-039 nc results 50 @phs 1, 90 @phs 2, 90 @phs 3, 10 @phs 4 -> peak = 90 @phs 2; a clear coinciding with the 10 result -> peak = 10 @phs 4.
REQ-040 Assert rx_rst one cycle after eop -> no tx_corr_vld or tx_nc_vld; all outputs read 0.
